// File: rtl/pwm_duty_controller.sv
// Push-button duty-step sequencer for the PWM generator: synchronise, debounce,
// saturate a shadow target, and commit it to the datapath only at period ends.
module pwm_duty_controller #(
    parameter int DUTY_W          = 4,
    parameter int DUTY_MAX        = 10,
    parameter int DUTY_RESET      = 5,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_btn_in,
    input  logic              dec_btn_in,
    input  logic              period_end_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic              update_out,
    output logic              pending_out,
    output logic              at_max_out,
    output logic              at_min_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DUTY_W-1:0] TGT_MAX  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] TGT_RST  = DUTY_W'(DUTY_RESET);

    // Bit 0 is the increase button, bit 1 the decrease button.
    logic [1:0]        w_btn;
    logic [1:0]        r_sync1;
    logic [1:0]        r_sync2;
    logic [1:0]        r_stable;
    logic [1:0]        w_press;
    logic [CNT_W-1:0]  r_cnt [2];
    logic [DUTY_W-1:0] r_target;
    logic [DUTY_W-1:0] r_duty;
    logic              r_update;

    assign w_btn = {dec_btn_in, inc_btn_in};

    // A press is the edge where the debounced level is about to flip 0->1.
    always_comb begin
        w_press = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            w_press[i] = r_sync2[i] && !r_stable[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Commit reads the pre-edge target, so a press on a period end waits a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= TGT_RST;
            r_duty   <= TGT_RST;
            r_update <= 1'b0;
        end else begin
            case (w_press)
                2'b01: if (r_target < TGT_MAX) r_target <= r_target + 1'b1;
                2'b10: if (r_target != '0)     r_target <= r_target - 1'b1;
                default: ;
            endcase
            if (period_end_in && (r_target != r_duty)) begin
                r_duty   <= r_target;
                r_update <= 1'b1;
            end else begin
                r_update <= 1'b0;
            end
        end
    end

    assign duty_out    = r_duty;
    assign update_out  = r_update;
    assign pending_out = (r_target != r_duty);
    assign at_max_out  = (r_target == TGT_MAX);
    assign at_min_out  = (r_target == '0);

endmodule

// File: tb/tb_pwm_duty_controller.sv
// Self-checking bench for pwm_duty_controller: directed scenarios plus random
// button/period traffic against a window-based behavioural model.
module tb_pwm_duty_controller;

    localparam int DW    = 4;
    localparam int DMAX  = 10;
    localparam int DRST  = 5;
    localparam int DEB   = 4;
    localparam int MAXE  = 20000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inc = 1'b0;
    logic          dec = 1'b0;
    logic          pe  = 1'b0;
    logic [DW-1:0] duty_out;
    logic          update_out, pending_out, at_max_out, at_min_out;

    int checks = 0;
    int errors = 0;

    pwm_duty_controller #(
        .DUTY_W(DW), .DUTY_MAX(DMAX), .DUTY_RESET(DRST), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst(rst), .inc_btn_in(inc), .dec_btn_in(dec),
        .period_end_in(pe), .duty_out(duty_out), .update_out(update_out),
        .pending_out(pending_out), .at_max_out(at_max_out), .at_min_out(at_min_out)
    );

    always #5 clk = ~clk;

    // Model: m_in[b][n] is the raw level seen at edge n after the last reset.
    // The level reaches the debouncer two edges later; the debounced state flips
    // once it has disagreed for DEB consecutive edges since the previous flip.
    bit m_in [2][0:MAXE];
    int m_n;
    int m_last [2];
    bit m_stable [2];
    int m_target, m_duty;
    bit m_upd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit seen_at(input int b, input int k);
        return (k >= 3) ? m_in[b][k-2] : 1'b0;
    endfunction

    task automatic model_step();
        bit btn [2];
        bit ev  [2];
        bit all;
        btn[0] = inc;
        btn[1] = dec;
        if (rst) begin
            m_n = 0;
            for (int b = 0; b < 2; b++) begin
                m_last[b] = 0;
                m_stable[b] = 1'b0;
            end
            m_target = DRST;
            m_duty   = DRST;
            m_upd    = 1'b0;
            return;
        end
        m_n++;
        for (int b = 0; b < 2; b++) begin
            ev[b] = 1'b0;
            if (m_n - m_last[b] >= DEB) begin
                all = 1'b1;
                for (int k = m_n - DEB + 1; k <= m_n; k++)
                    if (seen_at(b, k) == m_stable[b]) all = 1'b0;
                if (all) begin
                    m_stable[b] = !m_stable[b];
                    m_last[b]   = m_n;
                    ev[b]       = m_stable[b];
                end
            end
            m_in[b][m_n] = btn[b];
        end
        if (pe && m_target != m_duty) begin
            m_duty = m_target;
            m_upd  = 1'b1;
        end else begin
            m_upd = 1'b0;
        end
        if (ev[0] && !ev[1]) m_target = (m_target + 1 > DMAX) ? DMAX : m_target + 1;
        if (ev[1] && !ev[0]) m_target = (m_target - 1 < 0) ? 0 : m_target - 1;
    endtask

    task automatic cycle();
        logic [3:0] exp_flags;
        @(posedge clk);
        model_step();
        #1;
        exp_flags = {m_upd, m_target != m_duty, m_target == DMAX, m_target == 0};
        check("duty", 32'(duty_out), 32'(m_duty));
        check("flags", 32'({update_out, pending_out, at_max_out, at_min_out}), 32'(exp_flags));
    endtask

    task automatic do_reset();
        rst = 1'b1; inc = 1'b0; dec = 1'b0; pe = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    task automatic press(input bit is_inc);
        if (is_inc) inc = 1'b1; else dec = 1'b1;
        repeat (10) cycle();
        inc = 1'b0; dec = 1'b0;
        repeat (10) cycle();
    endtask

    task automatic period_pulse();
        pe = 1'b1; cycle();
        pe = 1'b0; cycle();
    endtask

    initial begin
        // Reset state
        do_reset();
        cycle();
        check("rst_duty", 32'(duty_out), 32'd5);
        check("rst_flags", 32'({update_out, pending_out, at_max_out, at_min_out}), 32'd0);

        // Press latency and single step while held
        inc = 1'b1;
        repeat (5) cycle();
        check("lat_early", 32'(pending_out), 32'd0);
        cycle();
        check("lat_edge6", 32'(pending_out), 32'd1);
        repeat (3) cycle();
        pe = 1'b1; cycle(); pe = 1'b0;
        check("lat_commit", 32'(duty_out), 32'd6);
        check("lat_upd_hi", 32'(update_out), 32'd1);
        cycle();
        check("lat_upd_lo", 32'(update_out), 32'd0);
        repeat (10) cycle();
        inc = 1'b0;
        repeat (10) cycle();
        period_pulse();
        check("lat_one_step", 32'(duty_out), 32'd6);

        // Glitch rejection
        do_reset();
        dec = 1'b1; repeat (3) cycle(); dec = 1'b0;
        repeat (10) cycle();
        period_pulse();
        check("glitch", 32'({duty_out, pending_out}), 32'({4'd5, 1'b0}));

        // Saturation both ways
        repeat (7) begin press(1'b1); period_pulse(); end
        check("sat_max", 32'({duty_out, at_max_out}), 32'({4'd10, 1'b1}));
        repeat (12) begin press(1'b0); period_pulse(); end
        check("sat_min", 32'({duty_out, at_min_out}), 32'({4'd0, 1'b1}));

        // Simultaneous presses cancel; coalesced presses commit once
        do_reset();
        inc = 1'b1; dec = 1'b1;
        repeat (10) cycle();
        inc = 1'b0; dec = 1'b0;
        repeat (10) cycle();
        check("simul", 32'({duty_out, pending_out}), 32'({4'd5, 1'b0}));
        repeat (3) press(1'b1);
        check("coal_hold", 32'({duty_out, pending_out}), 32'({4'd5, 1'b1}));
        pe = 1'b1; cycle(); pe = 1'b0;
        check("coal_commit", 32'({duty_out, update_out}), 32'({4'd8, 1'b1}));

        // Press on the same edge as period end
        do_reset();
        inc = 1'b1;
        repeat (5) cycle();
        pe = 1'b1; cycle(); pe = 1'b0;
        check("coll_hold", 32'({duty_out, pending_out, update_out}), 32'({4'd5, 1'b1, 1'b0}));
        repeat (3) cycle();
        pe = 1'b1; cycle(); pe = 1'b0;
        check("coll_next", 32'(duty_out), 32'd6);
        inc = 1'b0;
        repeat (10) cycle();

        // Reset while a commit is pending
        press(1'b1);
        check("mid_pend", 32'(pending_out), 32'd1);
        rst = 1'b1; cycle(); rst = 1'b0;
        check("mid_rst", 32'({duty_out, pending_out}), 32'({4'd5, 1'b0}));

        // Random traffic
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) inc = ~inc;
            if ($urandom_range(0, 7) == 0) dec = ~dec;
            pe  = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_controller.md
Name: pwm_duty_controller

Overview:
- Sequences the duty-cycle setting of the PWM generator from two push-button inputs (increase / decrease).
- Synchronises and debounces each button, and turns each clean press into one duty step.
- Holds the requested duty in a shadow register, saturating at 0 and DUTY_MAX.
- Commits the shadow value to the PWM datapath only at PWM period boundaries, so the output never glitches mid-period.

Parameters:
- DUTY_W, 4, width of the duty value.
- DUTY_MAX, 10, highest duty step (10 = 100 %); must be < 2^DUTY_W.
- DUTY_RESET, 5, duty step loaded on reset; must be <= DUTY_MAX.
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised button level must differ from its stable state before the stable state flips; must be >= 1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- inc_btn_in  input  1  raw asynchronous increase button, high = pressed.
- dec_btn_in  input  1  raw asynchronous decrease button, high = pressed.
- period_end_in  input  1  one-cycle pulse from the PWM counter on its last count of a period.
- duty_out  output  DUTY_W  committed duty step driving the PWM comparator.
- update_out  output  1  one-cycle pulse in the cycle after duty_out changes value.
- pending_out  output  1  shadow target differs from duty_out (combinational).
- at_max_out  output  1  shadow target == DUTY_MAX (combinational).
- at_min_out  output  1  shadow target == 0 (combinational).

Behaviour:
- Reset (rst high at a rising edge):
  - sync flops, stable states, debounce counters cleared to 0;
  - target and duty_out = DUTY_RESET;
  - update_out = 0.
  - Reset takes priority over all other activity, including reset asserted mid-debounce or mid-pending; no event survives it.
- Synchroniser: 2-FF chain per button; sync2 is the only version of the button used downstream.
- Debounce, per button, counter width clog2(DEBOUNCE_CYCLES+1):
  - sync2 == stable: counter <= 0.
  - sync2 != stable: counter increments. At the edge where it would reach DEBOUNCE_CYCLES, stable <= sync2 and counter <= 0.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored. Release is debounced identically.
- Press event: the stable state flipping 0->1; this acts on target at that same edge.
- Latency: button first sampled high at edge 1 and held → target changes at edge DEBOUNCE_CYCLES+2 (edge 6 with default). Holding a button gives exactly one step; there is no auto-repeat.
- Target update, at each edge:
  - inc event only: target <= min(target+1, DUTY_MAX).
  - dec event only: target <= max(target-1, 0).
  - Both events at the same edge: they cancel; target unchanged.
  - Saturation never wraps.
- Commit:
  - At an edge with period_end_in = 1 and target != duty_out: duty_out <= target (the value held before that edge); update_out <= 1 for exactly the next cycle.
  - Otherwise duty_out holds and update_out <= 0.
- Event and period_end_in at the same edge: the commit uses the old target, and the new target commits at the next period_end_in.
- Several presses between period ends: only the latest target is committed; intermediate values never appear on duty_out.
- period_end_in held high for multiple cycles: each high edge is a commit opportunity. No error results; after the first commit target == duty_out, so later edges are no-ops.
- All state changes occur on rising edges of clk only; no latches, no combinational loops.

Test Plan:
- Reset behaviour: rst high 2 cycles, then release with buttons low → duty_out = 5, target = 5, update_out = 0, pending_out = 0, at_max_out = 0, at_min_out = 0.
- Press latency: inc_btn_in high from edge 1, held 20 cycles → target = 6 at edge 6, pending_out = 1. period_end_in pulse at edge 10 → duty_out = 6 after edge 10, update_out high for cycle 10-11 only. Exactly one step while held.
- Glitch rejection: dec_btn_in high for 3 cycles then low → target and duty_out stay 5.
- Saturation: 7 separate clean inc presses from 5, each with period_end_in pulses → duty_out reaches 10 and stays 10, at_max_out = 1. Then 12 dec presses → duty_out = 0, at_min_out = 1, no wrap to 15.
- Simultaneous press and coalescing:
  - inc and dec raised on the same cycle → no change.
  - Then 3 inc presses with no period_end_in → duty_out stays 5, target = 8; a single period_end_in gives duty_out 5→8 with one update_out pulse.
- Edge collision and mid-operation reset:
  - inc event on the same edge as period_end_in → duty_out unchanged that edge, updates at the next period_end_in.
  - rst asserted while pending_out = 1 → duty_out = target = 5, pending_out = 0.
